legv8_multicycle_ctrl: RTL

// Multi-cycle control FSM for the LEGv8 core. Sits beside the decode stage and consumes the
// 11-bit opcode produced by instr_parse. Sequences fetch/decode/execute/memory/writeback over a

---
 rtl/legv8_multicycle_ctrl_pkg.sv | 55 +++++
 rtl/legv8_multicycle_ctrl_opcode_class.sv | 24 ++
 rtl/legv8_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller.
// Holds the opcode constants, FSM state encodings, datapath select codes,
// error codes and the opcode-classification record.
package legv8_multicycle_ctrl_pkg;

  // Full 11-bit opcodes (instruction[31:21])
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB- and B-format instructions are identified by a prefix only
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;  // opcode[10:3]
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;    // opcode[10:5]

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_ADDR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_WB_R    = 4'd6,
    S_WB_LD   = 4'd7,
    S_BR_CBZ  = 4'd8,
    S_BR_B    = 4'd9,
    S_HALT    = 4'd10
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [1:0] ALU_SRC_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_load;
    logic is_store;
    logic is_cbz;
    logic is_b;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  in  11  instruction[31:21]
//   cls_o     out     one-hot-or-illegal class record (op_class_t)
module legv8_opcode_class
  import legv8_multicycle_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_t   cls_o
);

  always_comb begin
    cls_o          = '0;
    cls_o.is_r     = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                     (opcode_i == OP_AND) || (opcode_i == OP_ORR);
    cls_o.is_load  = (opcode_i == OP_LDUR);
    cls_o.is_store = (opcode_i == OP_STUR);
    cls_o.is_cbz   = (opcode_i[10:3] == OP_CBZ_PFX);
    cls_o.is_b     = (opcode_i[10:5] == OP_B_PFX);
    cls_o.illegal  = !(cls_o.is_r || cls_o.is_load || cls_o.is_store ||
                       cls_o.is_cbz || cls_o.is_b);
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control FSM.
// Sequences fetch/decode/execute/memory/writeback over a single-port memory
// with a ready handshake, drives all datapath enables/selects, counts retired
// instructions and halts (sticky) on an illegal opcode or memory timeout.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, zero          decoded opcode field, ALU zero flag
//   mem_ready             memory completes the current access this cycle
//   pc_write .. alu_op    datapath enables and selects
//   state                 current state (debug)
//   instr_done            pulse on the last cycle of each instruction
//   instr_count           retired-instruction counter (wraps)
//   halted, err_code      halt indication and cause
module legv8_multicycle_ctrl
  import legv8_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg2loc,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic [1:0]       err_code
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       err_q, err_d;
  op_class_t        cls;

  legv8_opcode_class u_class (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    // The wait counter only advances while a memory state stalls; every other
    // cycle clears it, so it is always zero on entry to a memory state.
    tmo_d      = '0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = ALU_SRC_REG;
    alu_op     = ALU_OP_ADD;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_SRC_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        reg2loc = cls.is_store | cls.is_cbz;
        if (cls.is_r)                         state_d = S_EX_R;
        else if (cls.is_load || cls.is_store) state_d = S_EX_ADDR;
        else if (cls.is_cbz)                  state_d = S_BR_CBZ;
        else if (cls.is_b)                    state_d = S_BR_B;
        else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EX_R: begin
        alu_src_b = ALU_SRC_REG;
        alu_op    = ALU_OP_RTYPE;
        state_d   = S_WB_R;
      end
      S_EX_ADDR: begin
        alu_src_b = ALU_SRC_IMM;
        state_d   = cls.is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_LD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        reg2loc   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BR_CBZ: begin
        alu_op     = ALU_OP_PASSB;
        reg2loc    = 1'b1;
        pc_write   = zero;
        pc_src     = PC_SRC_BR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BR_B: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_BR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // While reset is held the FSM sits in FETCH, but nothing may be requested.
    if (!rst_n) begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_SEQ;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg2loc    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = ALU_SRC_REG;
      alu_op     = ALU_OP_ADD;
      instr_done = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign err_code    = err_q;

endmodule
